clk_div_multi: RTL

- Parametrised multi-channel clock-divider / tick generator. It is the successor to the single fixed 125 MHz divider.
- Each channel has a runtime-programmable half-period. Each channel drives a 50%-duty divided clock and a one-cycle toggle tick.
- Reprogramming is glitch-free: a new half-period takes effect only at that channel's terminal count.
- Sits beside the CPU clocking logic and feeds slow enables to the core, display and debug blocks.

---
 rtl/clk_div_pkg.sv | 27 ++
 rtl/clk_div_ch.sv | 107 ++++++++++
 rtl/clk_div_multi.sv | 76 +++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module   : clk_div_pkg
// Brief    : Shared constants and helpers for the multi-channel clock divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

  // Default counter width and reset half-period (125 MHz -> 1 Hz).
  localparam int CNT_W_DEF    = 32;
  localparam int DEF_HALF_DEF = 62500000;

  // Width of a channel index; a single channel still needs one select bit.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // A zero half-period would never wrap, so it is stored as 1 (clk/2).
  // Operates on 64 bits so it serves any counter width up to 64.
  function automatic logic [63:0] half_clamp(input logic [63:0] half);
    return (half == 64'd0) ? 64'd1 : half;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_ch.sv
// ============================================================================
// Module   : clk_div_ch
// Brief    : One divider channel: counter, active/pending half-period,
//            50% duty divided clock and toggle tick.
//            Optional macro CLK_DIV_MULTI_SYNC_EN adds the sync_i input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_HALF = DEF_HALF_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_half_i,
`ifdef CLK_DIV_MULTI_SYNC_EN
  input  logic             sync_i,
`endif
  output logic             pend_o,
  output logic             clk_out_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(half_clamp(64'(DEF_HALF)));

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_half_q, pend_half_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             w_wrap;
  logic             w_hold;
  logic             w_apply;

  // Terminal count of the active half-period.
  assign w_wrap = (cnt_q == (half_q - CNT_W'(1)));

  // Hold (counter and output cleared) when disabled or phase-aligned by sync.
`ifdef CLK_DIV_MULTI_SYNC_EN
  assign w_hold = !en_i || sync_i;
`else
  assign w_hold = !en_i;
`endif

  // A pending half-period only lands at a safe point so the output never glitches.
  assign w_apply = pend_q && (w_hold || w_wrap);

  // Next-state: count/toggle, pending apply, then capture of a new config write.
  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    clk_d       = clk_q;
    tick_d      = 1'b0;
    half_d      = half_q;
    pend_d      = pend_q;
    pend_half_d = pend_half_q;
    if (w_hold) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (w_wrap) begin
      cnt_d  = '0;
      clk_d  = !clk_q;
      tick_d = 1'b1;
    end
    if (w_apply) begin
      half_d = pend_half_q;
      pend_d = 1'b0;
    end
    // The top only grants a write while nothing is pending, so this never
    // collides with an apply on the same edge.
    if (wr_i) begin
      pend_half_d = wr_half_i;
      pend_d      = 1'b1;
    end
  end

  // Channel state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      half_q      <= RST_HALF;
      pend_half_q <= RST_HALF;
      pend_q      <= 1'b0;
      clk_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      pend_half_q <= pend_half_d;
      pend_q      <= pend_d;
      clk_q       <= clk_d;
      tick_q      <= tick_d;
    end
  end

  assign pend_o    = pend_q;
  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;

endmodule

`default_nettype wire

// File: rtl/clk_div_multi.sv
// ============================================================================
// Module   : clk_div_multi
// Brief    : Parametrised multi-channel clock divider / tick generator with a
//            shared valid/ready configuration port.
//            Optional macro CLK_DIV_MULTI_SYNC_EN adds the sync input that
//            phase-aligns all enabled channels.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int CNT_W    = CNT_W_DEF,
  parameter  int DEF_HALF = DEF_HALF_DEF,
  localparam int CH_W     = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
`ifdef CLK_DIV_MULTI_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] w_pend;
  logic [NUM_CH-1:0] w_wr;
  logic [CNT_W-1:0]  w_half;

  // Clamp once here so every channel stores a legal half-period.
  assign w_half = CNT_W'(half_clamp(64'(cfg_half)));

  // Ready follows the addressed channel's pending flag; an index beyond the
  // last channel is always accepted and simply matches no channel.
  always_comb begin
    cfg_ready = 1'b1;
    w_wr      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = !w_pend[i];
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      w_wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (ch_en[g]),
      .wr_i      (w_wr[g]),
      .wr_half_i (w_half),
`ifdef CLK_DIV_MULTI_SYNC_EN
      .sync_i    (sync),
`endif
      .pend_o    (w_pend[g]),
      .clk_out_o (clk_out[g]),
      .tick_o    (tick[g])
    );
  end

endmodule

`default_nettype wire
